// File: rtl/trws_pkg.sv
// trws_pkg: default widths plus saturating-add and min helpers shared by the TRW-S message passer.
package trws_pkg;
    localparam int LABELS_DEF = 16;
    localparam int LOG2_LABELS_DEF = 4;
    localparam int MESSAGE_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int INTERNAL_WIDTH_DEF = DATA_WIDTH_DEF + 2;

    typedef logic [31:0] word_t;

    // Saturates at 2^w-1; callers pass the datapath width so one helper serves any build.
    function automatic word_t sat_add(input word_t a, input word_t b, input int w);
        logic [32:0] s;
        logic [32:0] lim;
        s = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return s > lim ? lim[31:0] : s[31:0];
    endfunction

    function automatic word_t min2(input word_t a, input word_t b);
        return b < a ? b : a;
    endfunction
endpackage

// File: rtl/trws_dt_unit.sv
// trws_dt_unit: one direction's S3-S5 datapath: forward scan + min tree, backward scan, normalise/clamp.
// With TRWS_MP_MIN_OUT_EN defined, the per-beat minimum is also registered out at S5.
module trws_dt_unit
    import trws_pkg::*;
#(
    parameter int LABELS = LABELS_DEF,
    parameter int LOG2_LABELS = LOG2_LABELS_DEF,
    parameter int MESSAGE_WIDTH = MESSAGE_WIDTH_DEF,
    parameter int INTERNAL_WIDTH = INTERNAL_WIDTH_DEF,
    parameter int COST_WIDTH = MESSAGE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [LABELS*INTERNAL_WIDTH-1:0]  t,
    input  logic [COST_WIDTH-1:0]             step,
    input  logic [COST_WIDTH-1:0]             trunc,
    output logic [LABELS*MESSAGE_WIDTH-1:0]   msg
`ifdef TRWS_MP_MIN_OUT_EN
    ,
    output logic [INTERNAL_WIDTH-1:0]         m
`endif
);
    localparam int IW = INTERNAL_WIDTH;
    localparam int MW = MESSAGE_WIDTH;

    logic [IW-1:0] f_next [LABELS];
    logic [IW-1:0] m_next;
    logic [IW-1:0] f3 [LABELS];
    logic [IW-1:0] m3;
    logic [COST_WIDTH-1:0] step3, trunc3, trunc4;
    logic [IW-1:0] b_next [LABELS];
    logic [IW-1:0] b4 [LABELS];
    logic [IW-1:0] m4;
    logic [MW-1:0] o_next [LABELS];

    always_comb begin
        word_t acc;
        word_t tr [LABELS];
        acc = word_t'(t[IW-1:0]);
        f_next[0] = IW'(acc);
        for (int i = 1; i < LABELS; i++) begin
            acc = min2(word_t'(t[i*IW +: IW]), sat_add(acc, word_t'(step), IW));
            f_next[i] = IW'(acc);
        end
        for (int i = 0; i < LABELS; i++) tr[i] = word_t'(t[i*IW +: IW]);
        // In-place pairwise reduction; min2 keeps the left (lower-index) operand on ties.
        for (int l = 0; l < LOG2_LABELS; l++)
            for (int i = 0; i < (LABELS >> (l + 1)); i++)
                tr[i] = min2(tr[2*i], tr[2*i+1]);
        m_next = IW'(tr[0]);
    end

    always_comb begin
        word_t acc;
        acc = word_t'(f3[LABELS-1]);
        b_next[LABELS-1] = IW'(acc);
        for (int i = LABELS - 2; i >= 0; i--) begin
            acc = min2(word_t'(f3[i]), sat_add(acc, word_t'(step3), IW));
            b_next[i] = IW'(acc);
        end
    end

    always_comb begin
        for (int i = 0; i < LABELS; i++)
            o_next[i] = MW'(min2(min2(word_t'(b4[i] - m4), word_t'(trunc4)), (word_t'(1) << MW) - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LABELS; i++) begin
                f3[i] <= '0;
                b4[i] <= '0;
            end
            m3 <= '0;
            m4 <= '0;
            step3 <= '0;
            trunc3 <= '0;
            trunc4 <= '0;
            msg <= '0;
        end else if (en) begin
            for (int i = 0; i < LABELS; i++) begin
                f3[i] <= f_next[i];
                b4[i] <= b_next[i];
                msg[i*MW +: MW] <= o_next[i];
            end
            m3 <= m_next;
            m4 <= m3;
            step3 <= step;
            trunc3 <= trunc;
            trunc4 <= trunc3;
        end
    end

`ifdef TRWS_MP_MIN_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (en) m <= m4;
    end
`endif
endmodule

// File: rtl/trws_message_passer.sv
// trws_message_passer: six-stage flow-controlled TRW-S message update with truncated-linear distance transform.
// Define TRWS_MP_MIN_OUT_EN to expose the per-beat minima as horizontal_min / vertical_min.
module trws_message_passer
    import trws_pkg::*;
#(
    parameter int LABELS = LABELS_DEF,
    parameter int LOG2_LABELS = LOG2_LABELS_DEF,
    parameter int MESSAGE_WIDTH = MESSAGE_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int INTERNAL_WIDTH = DATA_WIDTH + 2,
    parameter int COST_WIDTH = MESSAGE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_message_forward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_message_backward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_message_forward,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_message_backward,
    input  logic [LABELS*DATA_WIDTH-1:0]      data,
    input  logic [COST_WIDTH-1:0]             cfg_step,
    input  logic [COST_WIDTH-1:0]             cfg_trunc,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_out,
    output logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_out,
`ifdef TRWS_MP_MIN_OUT_EN
    output logic [INTERNAL_WIDTH-1:0]         horizontal_min,
    output logic [INTERNAL_WIDTH-1:0]         vertical_min,
`endif
    output logic                              busy
);
    localparam int IW = INTERNAL_WIDTH;
    localparam int MW = MESSAGE_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic en;
    logic [5:0] valid;
    logic [MW-1:0] hf0 [LABELS];
    logic [MW-1:0] hb0 [LABELS];
    logic [MW-1:0] vf0 [LABELS];
    logic [MW-1:0] vb0 [LABELS];
    logic [DW-1:0] d0 [LABELS];
    logic [IW-1:0] p1 [LABELS];
    logic [MW-1:0] hb1 [LABELS];
    logic [MW-1:0] vb1 [LABELS];
    logic [LABELS*IW-1:0] ht2, vt2;
    logic [COST_WIDTH-1:0] step0, trunc0, step1, trunc1, step2, trunc2;

    // A single enable freezes the whole pipe whenever the output beat is refused.
    assign en = !(valid[5] && !out_ready);
    assign in_ready = en;
    assign out_valid = valid[5];
    assign busy = |valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid <= '0;
        else if (en) valid <= {valid[4:0], in_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LABELS; i++) begin
                hf0[i] <= '0;
                hb0[i] <= '0;
                vf0[i] <= '0;
                vb0[i] <= '0;
                d0[i] <= '0;
                p1[i] <= '0;
                hb1[i] <= '0;
                vb1[i] <= '0;
            end
            ht2 <= '0;
            vt2 <= '0;
            {step0, trunc0, step1, trunc1, step2, trunc2} <= '0;
        end else if (en) begin
            for (int i = 0; i < LABELS; i++) begin
                hf0[i] <= horizontal_message_forward[i*MW +: MW];
                hb0[i] <= horizontal_message_backward[i*MW +: MW];
                vf0[i] <= vertical_message_forward[i*MW +: MW];
                vb0[i] <= vertical_message_backward[i*MW +: MW];
                d0[i] <= data[i*DW +: DW];
                p1[i] <= IW'(sat_add(sat_add(word_t'(hf0[i]), word_t'(vf0[i]), IW), word_t'(d0[i]), IW));
                hb1[i] <= hb0[i];
                vb1[i] <= vb0[i];
                // Each outgoing direction excludes the message that arrived from that direction.
                ht2[i*IW +: IW] <= IW'(sat_add(word_t'(p1[i]), word_t'(vb1[i]), IW));
                vt2[i*IW +: IW] <= IW'(sat_add(word_t'(p1[i]), word_t'(hb1[i]), IW));
            end
            step0 <= cfg_step;
            trunc0 <= cfg_trunc;
            step1 <= step0;
            trunc1 <= trunc0;
            step2 <= step1;
            trunc2 <= trunc1;
        end
    end

    trws_dt_unit #(
        .LABELS(LABELS), .LOG2_LABELS(LOG2_LABELS), .MESSAGE_WIDTH(MW),
        .INTERNAL_WIDTH(IW), .COST_WIDTH(COST_WIDTH)
    ) h_dt (
        .clk(clk), .rst_n(rst_n), .en(en), .t(ht2), .step(step2), .trunc(trunc2),
        .msg(horizontal_out)
`ifdef TRWS_MP_MIN_OUT_EN
        , .m(horizontal_min)
`endif
    );

    trws_dt_unit #(
        .LABELS(LABELS), .LOG2_LABELS(LOG2_LABELS), .MESSAGE_WIDTH(MW),
        .INTERNAL_WIDTH(IW), .COST_WIDTH(COST_WIDTH)
    ) v_dt (
        .clk(clk), .rst_n(rst_n), .en(en), .t(vt2), .step(step2), .trunc(trunc2),
        .msg(vertical_out)
`ifdef TRWS_MP_MIN_OUT_EN
        , .m(vertical_min)
`endif
    );
endmodule

// File: tb/tb_trws_message_passer.sv
// tb_trws_message_passer: scoreboard bench; expected messages come from a direct min-over-labels model.
module tb_trws_message_passer;
    localparam int L = 16;
    localparam int MW = 6;
    localparam int DW = 8;
    localparam int IW = 10;
    localparam int CW = 6;

    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic in_ready, out_valid, busy, out_ready;
    logic [L*MW-1:0] hf = '0, hb = '0, vf = '0, vb = '0;
    logic [L*DW-1:0] data = '0;
    logic [CW-1:0] step = '0, trunc = '0;
    logic [L*MW-1:0] horizontal_out, vertical_out;
`ifdef TRWS_MP_MIN_OUT_EN
    logic [IW-1:0] horizontal_min, vertical_min;
`endif
    logic stall = 0, rand_ready = 0, rdy_bit = 1;
    int checks = 0, errors = 0, emitted = 0;

    typedef struct {
        logic [L*MW-1:0] h;
        logic [L*MW-1:0] v;
        int hm;
        int vm;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    assign out_ready = !stall && (!rand_ready || rdy_bit);

    trws_message_passer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .horizontal_message_forward(hf), .horizontal_message_backward(hb),
        .vertical_message_forward(vf), .vertical_message_backward(vb),
        .data(data), .cfg_step(step), .cfg_trunc(trunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .horizontal_out(horizontal_out), .vertical_out(vertical_out),
`ifdef TRWS_MP_MIN_OUT_EN
        .horizontal_min(horizontal_min), .vertical_min(vertical_min),
`endif
        .busy(busy)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // out[i] = min_j(t[j] + step*|i-j|) - min(t), clipped to trunc and the message range.
    function automatic logic [L*MW-1:0] ref_dir(input int t[L], input int s, input int tr, output int mn);
        logic [L*MW-1:0] o;
        int best, c, r;
        mn = t[0];
        for (int j = 1; j < L; j++) if (t[j] < mn) mn = t[j];
        for (int i = 0; i < L; i++) begin
            best = 1 << 20;
            for (int j = 0; j < L; j++) begin
                c = t[j] + s * (i > j ? i - j : j - i);
                if (c < best) best = c;
            end
            r = best - mn;
            if (r > tr) r = tr;
            if (r > 63) r = 63;
            o[i*MW +: MW] = MW'(r);
        end
        return o;
    endfunction

    function automatic exp_t model();
        exp_t e;
        int th[L], tv[L], p;
        for (int i = 0; i < L; i++) begin
            p = int'(hf[i*MW +: MW]) + int'(vf[i*MW +: MW]) + int'(data[i*DW +: DW]);
            th[i] = p + int'(vb[i*MW +: MW]);
            tv[i] = p + int'(hb[i*MW +: MW]);
        end
        e.h = ref_dir(th, int'(step), int'(trunc), e.hm);
        e.v = ref_dir(tv, int'(step), int'(trunc), e.vm);
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        rdy_bit = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else if (in_valid && in_ready) q.push_back(model());
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", 128'(in_ready), 128'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                emitted++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got=%0h want=none", horizontal_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("horizontal_out", 128'(horizontal_out), 128'(e.h));
                    check("vertical_out", 128'(vertical_out), 128'(e.v));
`ifdef TRWS_MP_MIN_OUT_EN
                    check("horizontal_min", 128'(horizontal_min), 128'(e.hm));
                    check("vertical_min", 128'(vertical_min), 128'(e.vm));
`endif
                end
            end
        end
    end

    task automatic fill(input int msg, input int dv, input int s, input int tr);
        for (int i = 0; i < L; i++) begin
            hf[i*MW +: MW] = MW'(msg);
            hb[i*MW +: MW] = MW'(msg);
            vf[i*MW +: MW] = MW'(msg);
            vb[i*MW +: MW] = MW'(msg);
            data[i*DW +: DW] = DW'(dv);
        end
        step = CW'(s);
        trunc = CW'(tr);
    endtask

    task automatic rand_fill();
        for (int i = 0; i < L; i++) begin
            hf[i*MW +: MW] = MW'($urandom_range(0, 63));
            hb[i*MW +: MW] = MW'($urandom_range(0, 63));
            vf[i*MW +: MW] = MW'($urandom_range(0, 63));
            vb[i*MW +: MW] = MW'($urandom_range(0, 63));
            data[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
        step = CW'($urandom_range(0, 63));
        trunc = CW'($urandom_range(0, 63));
    endtask

    task automatic send();
        int n;
        n = 0;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=stalled want=accepted");
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 128'(q.size()), 128'(0));
    endtask

    initial begin
        int first, bcnt, base, seen;
        #12;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_h_out", 128'(horizontal_out), 128'(0));
        check("reset_v_out", 128'(vertical_out), 128'(0));
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("ready_after_reset", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        fill(0, 0, 16, 32);
        send();
        first = -1;
        bcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (out_valid && first < 0) first = k;
        end
        check("latency", 128'(first), 128'(6));
        check("busy_cycles", 128'(bcnt), 128'(6));
        @(posedge clk);
        #1;

        fill(0, 100, 16, 32);
        data[5*DW +: DW] = '0;
        send();
        step = CW'(4);
        trunc = CW'(63);
        send();
        fill(63, 255, 16, 63);
        send();
        fill(0, 100, 16, 32);
        data[5*DW +: DW] = '0;
        send();
        step = CW'(4);
        send();
        drain();

        base = emitted;
        fork
            begin
                repeat (7) @(posedge clk);
                #1 stall = 1;
                repeat (6) @(posedge clk);
                #1 stall = 0;
            end
            for (int k = 0; k < 10; k++) begin
                rand_fill();
                send();
            end
        join
        drain();
        check("stall_count", 128'(emitted - base), 128'(10));

        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            rand_fill();
            send();
        end
        drain();
        rand_ready = 0;

        fill(0, 100, 16, 32);
        data[5*DW +: DW] = '0;
        for (int k = 0; k < 3; k++) send();
        #2 rst_n = 0;
        @(negedge clk);
        check("midreset_out_valid", 128'(out_valid), 128'(0));
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_h_out", 128'(horizontal_out), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_beat_after_reset", 128'(seen), 128'(0));
        check("queue_flushed", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
